// File: rtl/rrprioassign_pkg.sv
`default_nettype none
// =============================================================================
// Module   : rrprioassign_pkg
// Brief    : Shared sizing, scheduler state type and one-hot helpers
// Revision : 1.0
// =============================================================================
package rrprioassign_pkg;

    localparam int N    = 4;
    localparam int IDXW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rrsched_state_e;

    function automatic logic [IDXW-1:0] onehot2idx(input logic [N-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

endpackage : rrprioassign_pkg
`default_nettype wire

// File: rtl/rrprioassign.sv
`default_nettype none
// =============================================================================
// Module   : rrprioassign
// Brief    : Combinational round-robin picker, first request at or above p
// Revision : 1.0
// =============================================================================
module rrprioassign
    import rrprioassign_pkg::*;
(
    input  logic [N-1:0] r,
    input  logic [N-1:0] p,
    output logic [N-1:0] res
);

    logic [N-1:0] at_or_above;
    logic [N-1:0] masked;
    logic [N-1:0] pick;

    // p is one-hot, so p-1 marks every bit below the pointer; if nothing is
    // requested at or above it, wrap around and take the lowest request.
    always_comb begin
        at_or_above = ~(p - N'(1));
        masked      = r & at_or_above;
        pick        = (|masked) ? masked : r;
        res         = pick & (~pick + N'(1));
    end

endmodule : rrprioassign
`default_nettype wire

// File: rtl/rrprio_sched.sv
`default_nettype none
// =============================================================================
// Module   : rrprio_sched
// Brief    : Registered round-robin arbiter with hold limit and pointer rotation
// Revision : 1.0
// =============================================================================
module rrprio_sched
    import rrprioassign_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    prio
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    rrsched_state_e state, state_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [N-1:0]   prio_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [N-1:0]   sel;
    logic           hold_done;
    logic           release_now;

    rrprioassign u_pick (
        .r   (req),
        .p   (prio),
        .res (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            prio  <= N'(1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            prio  <= prio_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        hold_done   = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD - 1));
        release_now = ~(|(req & gnt)) | hold_done;

        state_nxt = state;
        gnt_nxt   = gnt;
        prio_nxt  = prio;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = sel;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_nxt   = '0;
                    prio_nxt  = rotl1(gnt);
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Derived purely from the gnt register, so all three outputs move together.
    always_comb begin
        gnt_valid = |gnt;
        gnt_idx   = onehot2idx(gnt);
    end

endmodule : rrprio_sched
`default_nettype wire

// File: tb/tb_rrprio_sched.sv
`default_nettype none
// =============================================================================
// Module   : tb_rrprio_sched
// Brief    : Directed and random scoreboard bench for rrprio_sched (N=4, MAX_HOLD=4)
// Revision : 1.0
// =============================================================================
module tb_rrprio_sched;
    import rrprioassign_pkg::*;

    localparam int MH = 4;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] prio;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    prio;

    int   tests;
    int   fails;
    exp_t sbq[$];

    // random-phase reference model
    logic         m_busy;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_prio;
    int           m_cnt;
    int           run_len;

    rrprio_sched #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .prio      (prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [IDXW-1:0] idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return IDXW'(i);
        end
        return '0;
    endfunction

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input logic [N-1:0] p);
        logic [N-1:0] res;
        int s;
        res = '0;
        s   = int'(idx_of(p));
        for (int k = 0; k < N; k++) begin
            int j;
            j = (s + k) % N;
            if (r[j]) begin
                res[j] = 1'b1;
                return res;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ep);
        chk({tag, ".gnt"},       32'(gnt),       32'(eg));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|eg));
        chk({tag, ".gnt_idx"},   32'(gnt_idx),   32'(idx_of(eg)));
        chk({tag, ".prio"},      32'(prio),      32'(ep));
    endtask

    // Drive req for one edge; the expectation is queued now and retired after the edge.
    task automatic cyc(input string tag, input logic [N-1:0] r,
                       input logic [N-1:0] eg, input logic [N-1:0] ep);
        exp_t e;
        e.gnt  = eg;
        e.prio = ep;
        sbq.push_back(e);
        req = r;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk_outputs(tag, e.gnt, e.prio);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        req    = '0;
        m_busy = 1'b0;
        m_gnt  = '0;
        m_prio = 4'b0001;
        m_cnt  = 0;
        run_len = 0;

        // 1: reset state, then first arbitration
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", 4'b0000, 4'b0001);
        rst_n = 1'b1;
        cyc("first", 4'b1111, 4'b0001, 4'b0001);

        // 2: rotation with one-cycle grants and a bubble between each
        cyc("rot_rel0", 4'b1110, 4'b0000, 4'b0010);
        cyc("rot_g1",   4'b1111, 4'b0010, 4'b0010);
        cyc("rot_rel1", 4'b1101, 4'b0000, 4'b0100);
        cyc("rot_g2",   4'b1111, 4'b0100, 4'b0100);
        cyc("rot_rel2", 4'b1011, 4'b0000, 4'b1000);
        cyc("rot_g3",   4'b1111, 4'b1000, 4'b1000);
        cyc("rot_rel3", 4'b0111, 4'b0000, 4'b0001);
        cyc("rot_g0",   4'b1111, 4'b0001, 4'b0001);
        cyc("rot_end",  4'b0000, 4'b0000, 4'b0010);

        // 3: timeout of a sole requester, then immediate re-grant
        repeat (4) cyc("to_hold", 4'b0100, 4'b0100, 4'b0010);
        cyc("to_bubble", 4'b0100, 4'b0000, 4'b1000);
        cyc("to_regnt",  4'b0100, 4'b0100, 4'b1000);

        // 5: no preemption by a newly raised request
        repeat (3) cyc("np_hold", 4'b0101, 4'b0100, 4'b1000);
        cyc("np_bubble", 4'b0101, 4'b0000, 4'b1000);
        cyc("np_next",   4'b0101, 4'b0001, 4'b1000);
        cyc("np_end",    4'b0000, 4'b0000, 4'b0010);

        // 4: fairness after forced release
        repeat (4) cyc("fair_a", 4'b0110, 4'b0010, 4'b0010);
        cyc("fair_b1", 4'b0110, 4'b0000, 4'b0100);
        repeat (4) cyc("fair_b", 4'b0110, 4'b0100, 4'b0100);
        cyc("fair_b2", 4'b0110, 4'b0000, 4'b1000);
        cyc("fair_c",  4'b0110, 4'b0010, 4'b1000);
        cyc("fair_end", 4'b0000, 4'b0000, 4'b0100);

        // 6: asynchronous reset between edges while granting
        cyc("ar_grant", 4'b1000, 4'b1000, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("ar_async", 4'b0000, 4'b0001);
        rst_n = 1'b1;
        cyc("ar_restart", 4'b1111, 4'b0001, 4'b0001);
        cyc("ar_end",     4'b0000, 4'b0000, 4'b0010);

        // random traffic against an independent reference model
        m_prio = 4'b0010;
        for (int c = 0; c < 1024; c++) begin
            logic [N-1:0] r;
            r = N'($urandom | $urandom);
            if (!m_busy) begin
                if (r != '0) begin
                    m_gnt  = model_pick(r, m_prio);
                    m_cnt  = 0;
                    m_busy = 1'b1;
                end
            end else if (((r & m_gnt) == '0) || (m_cnt == MH - 1)) begin
                m_prio = {m_gnt[N-2:0], m_gnt[N-1]};
                m_gnt  = '0;
                m_cnt  = 0;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
            cyc("rand", r, m_gnt, m_prio);
            run_len = (gnt != '0) ? run_len + 1 : 0;
            chk("rand.gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("rand.prio_onehot", 32'($onehot(prio)), 32'd1);
            chk("rand.hold_len",    32'(run_len <= MH), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rrprio_sched
`default_nettype wire
